// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: T0..T6 control-step sequencer for register-register ALU instructions; in: clk, clr (sync reset), start, mem_ready, ir_data; out: busy, done, illegal, datapath strobes, one-hot reg_in/reg_out, alu_op; define SEQ_MEM_TIMEOUT_EN to abort a T1 memory wait after MEM_TIMEOUT cycles
module alu_instr_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W = 5,
  parameter int REG_W = 4,
  parameter logic [OPC_W-1:0] LAST_ALU_OPC = 5'b10010,
  parameter logic [OPC_W-1:0] MUL_OPC = 5'b01111,
  parameter logic [OPC_W-1:0] DIV_OPC = 5'b10000,
  parameter logic [OPC_W-1:0] NEG_OPC = 5'b10001,
  parameter logic [OPC_W-1:0] NOT_OPC = 5'b10010,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] ir_data,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  pc_out,
  output logic                  mar_in,
  output logic                  inc_pc,
  output logic                  zlow_out,
  output logic                  zhigh_out,
  output logic                  pc_in,
  output logic                  read,
  output logic                  mdr_in,
  output logic                  mdr_out,
  output logic                  ir_in,
  output logic                  y_in,
  output logic                  z_in,
  output logic                  hi_in,
  output logic                  lo_in,
  output logic [NUM_REGS-1:0]   reg_in,
  output logic [NUM_REGS-1:0]   reg_out,
  output logic [OPC_W-1:0]      alu_op
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  state_t st, nxt;
  logic [OPC_W-1:0] opc_d, opc_q;
  logic [REG_W-1:0] ra_d, rb_d, rc_d, ra_q, rc_q;
  logic un_d, wide_d, bad_d, un_q, wide_q, done_q, ill_q, t1_wait, tmo, finish;
  logic unused_ir;
  assign opc_d = ir_data[DATA_WIDTH-1 -: OPC_W];
  assign ra_d = ir_data[DATA_WIDTH-1-OPC_W -: REG_W];
  assign rb_d = ir_data[DATA_WIDTH-1-OPC_W-REG_W -: REG_W];
  assign rc_d = ir_data[DATA_WIDTH-1-OPC_W-2*REG_W -: REG_W];
  assign unused_ir = ^ir_data[DATA_WIDTH-1-OPC_W-3*REG_W:0];
  assign un_d = opc_d == NEG_OPC || opc_d == NOT_OPC;
  assign wide_d = opc_d == MUL_OPC || opc_d == DIV_OPC;
  assign bad_d = opc_d > LAST_ALU_OPC || int'(ra_d) >= NUM_REGS || int'(rb_d) >= NUM_REGS ||
                 (!un_d && int'(rc_d) >= NUM_REGS);
  assign finish = (st == T4 && un_q) || (st == T5 && !wide_q) || st == T6;
  assign busy = st != IDLE;
  assign done = done_q;
  assign illegal = ill_q;
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_W-1:0] i);
    return NUM_REGS'(1) << i;
  endfunction
`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] t1_cnt;
  always_ff @(posedge clk)
    if (clr || st != T1) t1_cnt <= '0;
    else t1_cnt <= t1_cnt + CW'(1);
  assign tmo = st == T1 && !mem_ready && t1_cnt == CW'(MEM_TIMEOUT - 1);
`else
  localparam int unused_timeout = MEM_TIMEOUT;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (clr) begin
      st <= IDLE;
      opc_q <= '0;
      ra_q <= '0;
      rc_q <= '0;
      un_q <= 1'b0;
      wide_q <= 1'b0;
      done_q <= 1'b0;
      ill_q <= 1'b0;
      t1_wait <= 1'b0;
    end else begin
      st <= nxt;
      if (st == T3) begin
        opc_q <= opc_d;
        ra_q <= ra_d;
        rc_q <= rc_d;
        un_q <= un_d;
        wide_q <= wide_d;
      end
      done_q <= finish;
      ill_q <= (st == T3 && bad_d) || tmo;
      t1_wait <= st == T1;
    end
  end
  always_comb begin
    nxt = st;
    {pc_out, mar_in, inc_pc, zlow_out, zhigh_out, pc_in, read} = '0;
    {mdr_in, mdr_out, ir_in, y_in, z_in, hi_in, lo_in} = '0;
    reg_in = '0;
    reg_out = '0;
    alu_op = '0;
    case (st)
      IDLE: nxt = start ? T0 : IDLE;
      T0: begin
        {pc_out, mar_in, inc_pc, z_in} = '1;
        nxt = T1;
      end
      T1: begin
        {zlow_out, read, mdr_in} = '1;
        pc_in = !t1_wait;
        nxt = mem_ready ? T2 : tmo ? IDLE : T1;
      end
      T2: begin
        {mdr_out, ir_in} = '1;
        nxt = T3;
      end
      T3: begin
        reg_out = bad_d ? '0 : onehot(rb_d);
        y_in = !bad_d && !un_d;
        z_in = !bad_d && un_d;
        alu_op = (!bad_d && un_d) ? opc_d : '0;
        nxt = bad_d ? IDLE : T4;
      end
      T4: begin
        zlow_out = un_q;
        reg_in = un_q ? onehot(ra_q) : '0;
        reg_out = un_q ? '0 : onehot(rc_q);
        z_in = !un_q;
        alu_op = un_q ? '0 : opc_q;
        nxt = un_q ? IDLE : T5;
      end
      T5: begin
        zlow_out = 1'b1;
        lo_in = wide_q;
        reg_in = wide_q ? '0 : onehot(ra_q);
        nxt = wide_q ? T6 : IDLE;
      end
      T6: begin
        {zhigh_out, hi_in} = '1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule
